// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight destinations, load-use stalls, flushes, fwd selects.
// Define HZD_FORWARD_EN to enable operand forwarding; otherwise every RAW dependency stalls.
module hazard_ctrl_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int DEPTH   = LOAD_LAT + 2,
    localparam int FW      = $clog2(LOAD_LAT + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_jump,
    input  logic              ex_br_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The WB position is never compared (write-through register file), so only
    // positions 0..DEPTH-2 are stored. valid already folds in regwrite.
    localparam int NPOS = DEPTH - 1;

    logic [NPOS-1:0]   sb_valid;
    logic [NPOS-1:0]   sb_mem;
    logic [REG_AW-1:0] sb_wreg [NPOS];

    logic [NPOS-1:0] match_a;
    logic [NPOS-1:0] match_b;
    logic [NPOS-1:0] load_pos;
    logic            load_hz;
    logic            any_hz;
    logic            stall;
    logic            enter_valid;

    always_comb begin
        match_a  = '0;
        match_b  = '0;
        load_pos = '0;
        for (int p = 0; p < NPOS; p++) begin
            match_a[p]  = sb_valid[p] && (sb_wreg[p] == id_rs) && (id_rs != '0)
                          && id_use_rs && id_valid;
            match_b[p]  = sb_valid[p] && (sb_wreg[p] == id_rt) && (id_rt != '0)
                          && id_use_rt && id_valid;
            load_pos[p] = sb_mem[p] && (p < LOAD_LAT);
        end
    end

    assign load_hz = |((match_a | match_b) & load_pos);
    assign any_hz  = |(match_a | match_b);

`ifdef HZD_FORWARD_EN
    assign stall = load_hz & ~ex_br_taken;
`else
    // Load hazards are a subset of all matches; without forwarding any match stalls.
    assign stall = (any_hz | load_hz) & ~ex_br_taken;
`endif

    assign stall_pc    = stall;
    assign stall_ifid  = stall;
    assign flush_idex  = stall | ex_br_taken;
    assign flush_ifid  = ex_br_taken | (id_jump & id_valid);
    assign enter_valid = id_valid & id_regwrite & ~flush_idex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_mem   <= '0;
            for (int p = 0; p < NPOS; p++) sb_wreg[p] <= '0;
        end else begin
            sb_valid[0] <= enter_valid;
            sb_mem[0]   <= id_memread;
            sb_wreg[0]  <= id_wreg;
            for (int p = 1; p < NPOS; p++) begin
                sb_valid[p] <= sb_valid[p-1];
                sb_mem[p]   <= sb_mem[p-1];
                sb_wreg[p]  <= sb_wreg[p-1];
            end
        end
    end

`ifdef HZD_FORWARD_EN
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;

    // Scan oldest to youngest so the smallest position wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int p = NPOS - 1; p >= 0; p--) begin
            if (match_a[p]) sel_a = FW'(p + 1);
            if (match_b[p]) sel_b = FW'(p + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else if (flush_idex) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end
    end
`else
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Hazard and forwarding controller for the pipelined successor of the single-cycle MIPS datapath (IF/ID/EX/MEM.../WB).
- Keeps a registered scoreboard of in-flight destination registers and generates:
  - load-use stalls,
  - branch/jump flushes,
  - registered forwarding selects for both ALU operands.
- Parametrised in register-address width and load latency, so deeper memory stages need no redesign.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, number of stages after EX before load data is valid (1..3).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source A of the ID instruction.
- id_rt  in  REG_AW  source B of the ID instruction.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  REG_AW  destination (already muxed by RegDst).
- id_regwrite  in  1  instruction writes the register file.
- id_memread  in  1  instruction is a load.
- id_jump  in  1  jump decoded in ID.
- ex_br_taken  in  1  branch resolved taken in EX.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- flush_ifid  out  1  zero IF/ID register.
- flush_idex  out  1  insert bubble into ID/EX.
- fwd_a  out  FW  operand-A select for the instruction now in EX; FW = clog2(LOAD_LAT+2).
- fwd_b  out  FW  operand-B select, same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - all scoreboard entries invalid;
  - fwd_a = fwd_b = 0, stall_cnt = 0;
  - combinational stall/flush outputs are 0 because the scoreboard is empty.
- Scoreboard:
  - DEPTH = LOAD_LAT+2 positions; position 0 = EX, position DEPTH-1 = WB.
  - Each entry holds {valid, wreg, memread}.
  - Every cycle the entries shift toward WB. Position 0 loads the ID instruction, or a bubble (valid=0) when stall or flush_idex is active.
- Register 0 never creates a hazard or a forward.
- The register file is write-through, so WB-position producers are ignored. Only positions 0..DEPTH-2 are compared.
- Match at position p: entry valid, regwrite set, wreg == source, source used, id_valid.
- Load-use stall (combinational):
  - Condition: any matching entry with memread=1 and p < LOAD_LAT.
  - Action: stall_pc = stall_ifid = flush_idex = 1.
  - With LOAD_LAT=1 this yields exactly 1 bubble per load-use pair; with LOAD_LAT=L it yields L-p bubbles.
- Forwarding:
  - At the clock edge when ID advances into EX (no stall), fwd_a/fwd_b are registered as p+1 of the youngest (smallest p) matching entry, else 0.
  - Encoding: 0 = register file; k = value from pipeline position k (1 = MEM output, DEPTH-1 = WB).
  - When a bubble enters EX, fwd_a/fwd_b register to 0.
- Jump: id_jump & id_valid → flush_ifid=1 for that cycle.
- Branch: ex_br_taken → flush_ifid=1 and flush_idex=1. Stall outputs are forced to 0 (branch wins over load-use stall).
- Simultaneous id_jump and ex_br_taken: the branch action applies; the jump is discarded with the flushed ID instruction.
- stall_cnt increments on every cycle with stall_pc=1 and saturates at all-ones.
- Reset mid-stall: the stall drops asynchronously and the pipeline restarts empty.

Optional Feature:
- HZD_FORWARD_EN defined:
  - forwarding as above;
  - stalls only for load-use.
- Not defined:
  - fwd_a/fwd_b are constant 0;
  - stall whenever any matching entry exists at positions 0..DEPTH-2, for both ALU and load producers;
  - the fwd registers are removed.

Test Plan:
- Reset, then add $3,$1,$2 followed by sub $4,$3,$5, LOAD_LAT=1, forwarding on → no stall; fwd_a=1 in the sub's EX cycle, fwd_b=0.
- lw $3,0($1) then add $4,$3,$3 → exactly one cycle with stall_pc=stall_ifid=flush_idex=1; next EX cycle fwd_a=fwd_b=2; stall_cnt=1.
- Same lw/add pair with LOAD_LAT=3 → 3 stall cycles; then fwd_a=fwd_b=4; stall_cnt=3.
- add $0,$1,$2 then add $5,$0,$0 → no stall, fwd_a=fwd_b=0.
- lw→dependent add with ex_br_taken=1 in the stall cycle → stall_pc=0, flush_ifid=flush_idex=1; id_jump asserted in the same cycle has no extra effect.
- HZD_FORWARD_EN undefined: add $3 then dependent sub → 2 stall cycles, fwd outputs 0. Assert rst_n=0 mid-stall → all outputs 0 immediately and stall_cnt=0.
